slot_reel_ctrl: RTL

Game sequencer for the three-reel slot machine.
- Gates the enables of three external 4-bit LFSR reel generators.
- Freezes the reels one by one on player stop presses or on timeout.
- Latches the stopped symbols, evaluates the win and maintains the credit counter.
- Sits between the debounced button/coin pulse logic and the reel LFSRs/display.

---
 rtl/slot_reel_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/slot_reel_ctrl.sv
// slot_reel_ctrl -- three-reel slot machine game sequencer.
// Gates the enables of three external reel LFSRs and freezes the reels one by
// one, either on a player stop press or on timeout. It then latches the stopped
// symbols, evaluates the win and maintains a saturating credit counter.
// Optional build macro SLOT_REEL_CTRL_FREE_SPIN_EN adds the free_spin output.
// When enabled, a triple of all-ones symbols grants one free game.

module slot_reel_ctrl #(
   parameter int SYMBOL_W      = 4,
   parameter int CREDIT_W      = 8,
   parameter int MIN_SPIN_CYC  = 16,
   parameter int AUTO_STOP_CYC = 1024,
   parameter int PAYOUT_TRIPLE = 10,
   parameter int PAYOUT_PAIR   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  coin,
   input  logic                  start,
   input  logic                  stop,
   input  logic [3*SYMBOL_W-1:0] lfsr_val,
   output logic [2:0]            lfsr_en,
   output logic [3*SYMBOL_W-1:0] reel_sym,
   output logic [CREDIT_W-1:0]   credits,
   output logic                  busy,
   output logic                  win_valid,
   output logic [CREDIT_W-1:0]   win_amount
`ifdef SLOT_REEL_CTRL_FREE_SPIN_EN
   ,
   output logic                  free_spin
`endif
);

   // Counter is wide enough to hold the saturation value itself.
   localparam int CNT_W = $clog2(AUTO_STOP_CYC + 1);
   localparam logic [CNT_W-1:0]    CNT_MIN    = CNT_W'(MIN_SPIN_CYC);
   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(AUTO_STOP_CYC - 1);
   localparam logic [CNT_W-1:0]    CNT_SAT    = CNT_W'(AUTO_STOP_CYC);
   localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
   localparam logic [CREDIT_W-1:0] PAY_TRI    = CREDIT_W'(PAYOUT_TRIPLE);
   localparam logic [CREDIT_W-1:0] PAY_PAIR   = CREDIT_W'(PAYOUT_PAIR);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SPIN3  = 3'd1,
      ST_SPIN2  = 3'd2,
      ST_SPIN1  = 3'd3,
      ST_EVAL   = 3'd4,
      ST_PAYOUT = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [2:0]              en_q, en_d;
   logic [3*SYMBOL_W-1:0]   sym_q, sym_d;
   logic [CREDIT_W-1:0]     credits_q, credits_d;
   logic [CREDIT_W-1:0]     win_q, win_d;

   logic                    use_free;
   logic                    start_ok;
   logic                    stop_evt;
   logic                    spinning;
   logic [1:0]              reel_idx;
   logic [CREDIT_W-1:0]     payout;
   logic [CREDIT_W:0]       credit_sum;

   logic [SYMBOL_W-1:0]     sym_slot  [3];
   logic [SYMBOL_W-1:0]     lfsr_slot [3];

   // Unpack the three reel lanes for readable indexing.
   for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      assign sym_slot[gi]  = sym_q[gi*SYMBOL_W +: SYMBOL_W];
      assign lfsr_slot[gi] = lfsr_val[gi*SYMBOL_W +: SYMBOL_W];
   end

`ifdef SLOT_REEL_CTRL_FREE_SPIN_EN
   logic free_q, free_d;
   assign use_free  = free_q;
   assign free_spin = free_q;
`else
   assign use_free  = 1'b0;
`endif

   // A start is honoured only from IDLE and only if the game can be paid for.
   assign start_ok = (state_q == ST_IDLE) && start && ((credits_q != '0) || use_free);

   assign spinning = (state_q == ST_SPIN3) || (state_q == ST_SPIN2) || (state_q == ST_SPIN1);

   // Early presses are simply dropped; the timeout fires on the last counted cycle.
   assign stop_evt = spinning && ((stop && (cnt_q >= CNT_MIN)) || (cnt_q == CNT_LAST));

   // Reels always stop in order 0, 1, 2, so the phase identifies the reel to freeze.
   always_comb begin
      reel_idx = 2'd0;
      case (state_q)
         ST_SPIN2: reel_idx = 2'd1;
         ST_SPIN1: reel_idx = 2'd2;
         default:  reel_idx = 2'd0;
      endcase
   end

   // Win evaluation on the latched symbols: triple beats pair, otherwise nothing.
   always_comb begin
      payout = '0;
      if ((sym_slot[0] == sym_slot[1]) && (sym_slot[1] == sym_slot[2])) begin
         payout = PAY_TRI;
      end else if ((sym_slot[0] == sym_slot[1]) || (sym_slot[1] == sym_slot[2]) ||
                   (sym_slot[0] == sym_slot[2])) begin
         payout = PAY_PAIR;
      end
   end

   // Game sequencing: next state, phase counter, reel enables, symbol latches, win.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      sym_d   = sym_q;
      win_d   = win_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start_ok) begin
               en_d    = 3'b111;
               state_d = ST_SPIN3;
            end
         end
         ST_SPIN3, ST_SPIN2, ST_SPIN1: begin
            if (stop_evt) begin
               cnt_d          = '0;
               en_d[reel_idx] = 1'b0;
               sym_d[reel_idx*SYMBOL_W +: SYMBOL_W] = lfsr_slot[reel_idx];
               case (state_q)
                  ST_SPIN3: state_d = ST_SPIN2;
                  ST_SPIN2: state_d = ST_SPIN1;
                  default:  state_d = ST_EVAL;
               endcase
            end else if (cnt_q != CNT_SAT) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_EVAL: begin
            win_d   = payout;
            state_d = ST_PAYOUT;
         end
         ST_PAYOUT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Credit update: coin, start cost and payout are folded into a single add.
   always_comb begin
      credit_sum = {1'b0, credits_q} + (CREDIT_W+1)'(coin);
      if (state_q == ST_PAYOUT) begin
         credit_sum = credit_sum + {1'b0, win_q};
      end
      if (start_ok && !use_free) begin
         // credits_q > 0 here, so the decrement cannot underflow and,
         // with at most one coin, the result cannot overflow.
         credits_d = CREDIT_W'(credit_sum - (CREDIT_W+1)'(1));
      end else if (credit_sum[CREDIT_W]) begin
         credits_d = CREDIT_MAX;
      end else begin
         credits_d = credit_sum[CREDIT_W-1:0];
      end
   end

   // State and datapath registers; reset aborts any game in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         en_q      <= '0;
         sym_q     <= '0;
         credits_q <= '0;
         win_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         en_q      <= en_d;
         sym_q     <= sym_d;
         credits_q <= credits_d;
         win_q     <= win_d;
      end
   end

`ifdef SLOT_REEL_CTRL_FREE_SPIN_EN
   // Free game token: granted by an all-ones triple, spent by the next start.
   always_comb begin
      free_d = free_q;
      if (start_ok) begin
         free_d = 1'b0;
      end
      if ((state_q == ST_PAYOUT) && (sym_q == '1)) begin
         free_d = 1'b1;
      end
   end

   // Free game token register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         free_q <= 1'b0;
      end else begin
         free_q <= free_d;
      end
   end
`endif

   assign lfsr_en    = en_q;
   assign reel_sym   = sym_q;
   assign credits    = credits_q;
   assign win_amount = win_q;
   assign busy       = (state_q != ST_IDLE);
   assign win_valid  = (state_q == ST_PAYOUT);

endmodule
